byte_width_convert: RTL and testbench

- Width adapter between a wide "use" port and a narrower "mem" port, both using the enable/isWrite/writeMask/addr/hold memory protocol.
- Each accepted use-side access is split into RATIO = USE_DATA_BYTE/MEM_DATA_BYTE sequential mem-side beats.
- Read beats are reassembled into one wide word.
- Sits between a wide master (e.g. a 64-bit driver) and a narrow byte-masked memory (e.g. a 16-bit RAM).

---
 rtl/byte_width_convert.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_byte_width_convert.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_width_convert.sv
// -----------------------------------------------------------------------------
// byte_width_convert
//
// Width adapter between a wide "use" master port and a narrower "mem" port.
// Both sides follow the enable/isWrite/writeMask/addr/hold protocol: a request
// is accepted when enable=1 and hold=0, and read data is valid the cycle after
// acceptance. Each use access is split into RATIO = USE_DATA_BYTE/MEM_DATA_BYTE
// little-endian mem beats (beat 0 = lowest bytes); read beats are reassembled
// into one wide word.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   useEnable_i/useIsWrite_i     use request valid / direction
//   useWriteMask_i               per-byte write enable (USE_DATA_BYTE bits)
//   useAddr_i                    use-word address
//   useWriteData_i               wide write data
//   useReadData_o                wide read data, holds last completed read
//   useHold_o                    use-side stall
//   memEnable_o/memIsWrite_o     beat valid / direction (registered)
//   memWriteMask_o               beat byte mask (registered)
//   memAddr_o                    beat address = addr*RATIO + k (registered)
//   memWriteData_o               beat write data (registered)
//   memReadData_i                beat read data
//   memHold_i                    mem-side stall
//
// Optional feature macro: BYTECONVERT_SKIP_EMPTY_BEAT_EN
//   When defined, write beats whose mask slice is all-zero are not issued;
//   a write with no remaining beat goes straight from IDLE to DONE.
// -----------------------------------------------------------------------------
module byte_width_convert #(
  parameter int USE_ADDR_SIZE = 32,
  parameter int USE_DATA_BYTE = 8,
  parameter int MEM_ADDR_SIZE = 32,
  parameter int MEM_DATA_BYTE = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         useEnable_i,
  input  logic                         useIsWrite_i,
  input  logic [USE_DATA_BYTE-1:0]     useWriteMask_i,
  input  logic [USE_ADDR_SIZE-1:0]     useAddr_i,
  input  logic [8*USE_DATA_BYTE-1:0]   useWriteData_i,
  output logic [8*USE_DATA_BYTE-1:0]   useReadData_o,
  output logic                         useHold_o,
  output logic                         memEnable_o,
  output logic                         memIsWrite_o,
  output logic [MEM_DATA_BYTE-1:0]     memWriteMask_o,
  output logic [MEM_ADDR_SIZE-1:0]     memAddr_o,
  output logic [8*MEM_DATA_BYTE-1:0]   memWriteData_o,
  input  logic [8*MEM_DATA_BYTE-1:0]   memReadData_i,
  input  logic                         memHold_i
);

  localparam int unsigned RATIO  = USE_DATA_BYTE / MEM_DATA_BYTE;
  localparam int unsigned MB     = MEM_DATA_BYTE;
  localparam int unsigned UW     = 8 * USE_DATA_BYTE;
  localparam int unsigned MW     = 8 * MEM_DATA_BYTE;
  localparam int unsigned K_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned CALC_W = (USE_ADDR_SIZE + K_W + 1 > MEM_ADDR_SIZE) ?
                                   (USE_ADDR_SIZE + K_W + 1) : MEM_ADDR_SIZE;

  if (MEM_DATA_BYTE < 1 || USE_DATA_BYTE < MEM_DATA_BYTE ||
      (USE_DATA_BYTE % MEM_DATA_BYTE) != 0) begin : g_bad_ratio
    $error("byte_width_convert: USE_DATA_BYTE must be an integer multiple of MEM_DATA_BYTE");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT,
    ST_DONE
  } state_t;

  state_t                     r_state, w_stateNext;
  logic [K_W-1:0]             r_k, w_kNext;

  logic                       r_isWrite;
  logic [USE_ADDR_SIZE-1:0]   r_addr;
  logic [USE_DATA_BYTE-1:0]   r_mask;
  logic [UW-1:0]              r_data;

  logic                       r_memEnable,    w_memEnableNext;
  logic                       r_memIsWrite,   w_memIsWriteNext;
  logic [MB-1:0]              r_memWriteMask, w_memWriteMaskNext;
  logic [MEM_ADDR_SIZE-1:0]   r_memAddr,      w_memAddrNext;
  logic [MW-1:0]              r_memWriteData, w_memWriteDataNext;

  logic                       r_cap,    w_capNext;
  logic [K_W-1:0]             r_capIdx, w_capIdxNext;
  logic [UW-1:0]              r_rdBuf;
  logic [UW-1:0]              r_useReadData;
  logic [UW-1:0]              w_rdFull;

  logic                       w_latch;
  logic                       w_rdDone;
  logic                       w_loadBeat;
  logic [K_W-1:0]             w_beatK;
  logic [K_W:0]               w_search;

  // In IDLE the first beat is built straight from the use inputs, since the
  // latched copies only become valid on the same edge that issues beat 0.
  logic                       w_srcIsWrite;
  logic [USE_ADDR_SIZE-1:0]   w_srcAddr;
  logic [USE_DATA_BYTE-1:0]   w_srcMask;
  logic [UW-1:0]              w_srcData;
  logic [RATIO-1:0]           w_present;

  // Returns {found, index} of the first present beat at or after 'start'.
  function automatic logic [K_W:0] find_next(input logic [RATIO-1:0] present,
                                             input int unsigned start);
    logic           found;
    logic [K_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (!found && i >= start && present[i]) begin
        found = 1'b1;
        idx   = K_W'(i);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [MEM_ADDR_SIZE-1:0] beat_addr(input logic [USE_ADDR_SIZE-1:0] addr,
                                                         input logic [K_W-1:0] k);
    logic [CALC_W-1:0] t;
    t = CALC_W'(addr) * CALC_W'(RATIO) + CALC_W'(k);
    return t[MEM_ADDR_SIZE-1:0];
  endfunction

  always_comb begin
    if (r_state == ST_IDLE) begin
      w_srcIsWrite = useIsWrite_i;
      w_srcAddr    = useAddr_i;
      w_srcMask    = useWriteMask_i;
      w_srcData    = useWriteData_i;
    end else begin
      w_srcIsWrite = r_isWrite;
      w_srcAddr    = r_addr;
      w_srcMask    = r_mask;
      w_srcData    = r_data;
    end
  end

  always_comb begin
    w_present = '1;
`ifdef BYTECONVERT_SKIP_EMPTY_BEAT_EN
    for (int unsigned i = 0; i < RATIO; i++) begin
      w_present[i] = !w_srcIsWrite || (w_srcMask[i*MB +: MB] != '0);
    end
`endif
  end

  always_comb begin
    w_stateNext        = r_state;
    w_kNext            = r_k;
    w_latch            = 1'b0;
    w_rdDone           = 1'b0;
    w_capNext          = 1'b0;
    w_capIdxNext       = r_capIdx;
    w_loadBeat         = 1'b0;
    w_beatK            = '0;
    w_search           = '0;
    w_memEnableNext    = 1'b0;
    w_memIsWriteNext   = 1'b0;
    w_memWriteMaskNext = '0;
    w_memAddrNext      = '0;
    w_memWriteDataNext = '0;

    case (r_state)
      ST_IDLE: begin
        if (useEnable_i) begin
          w_latch  = 1'b1;
          w_search = find_next(w_present, 0);
          if (w_search[K_W]) begin
            w_stateNext = ST_BEAT;
            w_kNext     = w_search[K_W-1:0];
            w_loadBeat  = 1'b1;
            w_beatK     = w_search[K_W-1:0];
          end else begin
            w_stateNext = ST_DONE;
            w_kNext     = '0;
          end
        end
      end

      ST_BEAT: begin
        if (memHold_i) begin
          w_memEnableNext    = r_memEnable;
          w_memIsWriteNext   = r_memIsWrite;
          w_memWriteMaskNext = r_memWriteMask;
          w_memAddrNext      = r_memAddr;
          w_memWriteDataNext = r_memWriteData;
        end else begin
          // Beat r_k is accepted now; its read data arrives next cycle.
          w_capNext    = !r_isWrite;
          w_capIdxNext = r_k;
          w_search     = find_next(w_present, int'(r_k) + 1);
          if (w_search[K_W]) begin
            w_kNext    = w_search[K_W-1:0];
            w_loadBeat = 1'b1;
            w_beatK    = w_search[K_W-1:0];
          end else begin
            w_stateNext = ST_DONE;
            w_kNext     = '0;
          end
        end
      end

      ST_DONE: begin
        w_stateNext = ST_IDLE;
        w_kNext     = '0;
        w_rdDone    = !r_isWrite;
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_kNext     = '0;
      end
    endcase

    if (w_loadBeat) begin
      w_memEnableNext    = 1'b1;
      w_memIsWriteNext   = w_srcIsWrite;
      w_memWriteMaskNext = w_srcMask[w_beatK*MB +: MB];
      w_memAddrNext      = beat_addr(w_srcAddr, w_beatK);
      w_memWriteDataNext = w_srcData[w_beatK*MW +: MW];
    end
  end

  // Merges the pending read slice so DONE can publish the full word at once.
  always_comb begin
    w_rdFull = r_rdBuf;
    if (r_cap) begin
      w_rdFull[r_capIdx*MW +: MW] = memReadData_i;
    end
  end

  always_comb begin
    case (r_state)
      ST_IDLE: useHold_o = useEnable_i;
      ST_BEAT: useHold_o = 1'b1;
      default: useHold_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_stateNext;
      r_k     <= w_kNext;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_isWrite      <= 1'b0;
      r_addr         <= '0;
      r_mask         <= '0;
      r_data         <= '0;
      r_memEnable    <= 1'b0;
      r_memIsWrite   <= 1'b0;
      r_memWriteMask <= '0;
      r_memAddr      <= '0;
      r_memWriteData <= '0;
      r_cap          <= 1'b0;
      r_capIdx       <= '0;
      r_rdBuf        <= '0;
      r_useReadData  <= '0;
    end else begin
      if (w_latch) begin
        r_isWrite <= useIsWrite_i;
        r_addr    <= useAddr_i;
        r_mask    <= useWriteMask_i;
        r_data    <= useWriteData_i;
      end
      r_memEnable    <= w_memEnableNext;
      r_memIsWrite   <= w_memIsWriteNext;
      r_memWriteMask <= w_memWriteMaskNext;
      r_memAddr      <= w_memAddrNext;
      r_memWriteData <= w_memWriteDataNext;
      r_cap          <= w_capNext;
      r_capIdx       <= w_capIdxNext;
      if (r_cap) begin
        r_rdBuf <= w_rdFull;
      end
      if (w_rdDone) begin
        r_useReadData <= w_rdFull;
      end
    end
  end

  assign useReadData_o  = r_useReadData;
  assign memEnable_o    = r_memEnable;
  assign memIsWrite_o   = r_memIsWrite;
  assign memWriteMask_o = r_memWriteMask;
  assign memAddr_o      = r_memAddr;
  assign memWriteData_o = r_memWriteData;

endmodule

// File: tb/tb_byte_width_convert.sv
// -----------------------------------------------------------------------------
// tb_byte_width_convert
//
// Bench for byte_width_convert with default parameters (64-bit use side,
// 16-bit mem side, RATIO=4). A behavioural 16-bit byte-masked RAM answers the
// mem port; expected mem beats are queued when a use request is driven and
// compared as the DUT issues them. Use-side read data and access latency are
// checked against constants in a vector table, followed by stall and
// mid-transaction reset sequences.
// -----------------------------------------------------------------------------
module tb_byte_width_convert;

  logic        clk = 1'b0;
  logic        rst;
  logic        useEnable_i;
  logic        useIsWrite_i;
  logic [7:0]  useWriteMask_i;
  logic [31:0] useAddr_i;
  logic [63:0] useWriteData_i;
  logic [63:0] useReadData_o;
  logic        useHold_o;
  logic        memEnable_o;
  logic        memIsWrite_o;
  logic [1:0]  memWriteMask_o;
  logic [31:0] memAddr_o;
  logic [15:0] memWriteData_o;
  logic [15:0] memReadData_i = '0;
  logic        memHold_i;

  always #5 clk = ~clk;

  byte_width_convert #(
    .USE_ADDR_SIZE (32),
    .USE_DATA_BYTE (8),
    .MEM_ADDR_SIZE (32),
    .MEM_DATA_BYTE (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .useEnable_i    (useEnable_i),
    .useIsWrite_i   (useIsWrite_i),
    .useWriteMask_i (useWriteMask_i),
    .useAddr_i      (useAddr_i),
    .useWriteData_i (useWriteData_i),
    .useReadData_o  (useReadData_o),
    .useHold_o      (useHold_o),
    .memEnable_o    (memEnable_o),
    .memIsWrite_o   (memIsWrite_o),
    .memWriteMask_o (memWriteMask_o),
    .memAddr_o      (memAddr_o),
    .memWriteData_o (memWriteData_o),
    .memReadData_i  (memReadData_i),
    .memHold_i      (memHold_i)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [63:0] exp_rd;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  mask;
    logic [15:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  logic [31:0] hold_addr = '0;
  int          hold_left = 0;

  logic [15:0] ram [0:255] = '{default: '0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: byte-masked writes, registered read data.
  always @(posedge clk) begin
    if (memEnable_o && !memHold_i) begin
      if (memIsWrite_o) begin
        if (memWriteMask_o[0]) ram[memAddr_o[7:0]][7:0]  <= memWriteData_o[7:0];
        if (memWriteMask_o[1]) ram[memAddr_o[7:0]][15:8] <= memWriteData_o[15:8];
      end else begin
        memReadData_i <= ram[memAddr_o[7:0]];
      end
    end
  end

  // Stall generator: holds the beat at hold_addr for hold_left cycles.
  initial begin
    memHold_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_left > 0 && memEnable_o && memAddr_o == hold_addr) begin
        memHold_i = 1'b1;
        hold_left--;
      end else begin
        memHold_i = 1'b0;
      end
    end
  end

  // Beat monitor: every presented beat must match the head of the queue
  // (including while stalled); it is popped on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && memEnable_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got beat at addr %h expected none", memAddr_o);
        end else begin
          check("beat_iswrite", 64'(memIsWrite_o),   64'(exp_q[0].wr));
          check("beat_addr",    64'(memAddr_o),      64'(exp_q[0].addr));
          check("beat_mask",    64'(memWriteMask_o), 64'(exp_q[0].mask));
          check("beat_data",    64'(memWriteData_o), 64'(exp_q[0].data));
          if (!memHold_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic do_access(input logic wr, input logic [31:0] addr, input logic [7:0] mask,
                           input logic [63:0] data, input int extra, input logic [63:0] exp_rd,
                           input string tag);
    int cyc;
    int nb;
    logic [1:0] ms;
    beat_t b;
    nb = 0;
    @(posedge clk);
    #1;
    useEnable_i    = 1'b1;
    useIsWrite_i   = wr;
    useAddr_i      = addr;
    useWriteMask_i = mask;
    useWriteData_i = data;
    for (int k = 0; k < 4; k++) begin
      ms = mask[k*2 +: 2];
`ifdef BYTECONVERT_SKIP_EMPTY_BEAT_EN
      if (wr && ms == 2'b00) continue;
`endif
      b.wr   = wr;
      b.addr = addr * 4 + 32'(k);
      b.mask = ms;
      b.data = data[k*16 +: 16];
      exp_q.push_back(b);
      nb++;
    end
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (!useHold_o) break;
      cyc++;
      if (cyc > 60) break;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(nb + 1 + extra));
    @(posedge clk);
    #1;
    useEnable_i = 1'b0;
    check({tag, "_rdata"}, useReadData_o, exp_rd);
    check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 32'd3, 8'hFF, 64'h1122334455667788, 64'h0};
    tbl[1] = '{1'b0, 32'd3, 8'h00, 64'h0,                64'h1122334455667788};
    tbl[2] = '{1'b1, 32'd3, 8'h0C, 64'hAAAABBBBCCCCDDDD, 64'h1122334455667788};
    tbl[3] = '{1'b0, 32'd3, 8'h00, 64'h0,                64'h11223344CCCC7788};
    tbl[4] = '{1'b1, 32'd7, 8'h30, 64'h0123456789ABCDEF, 64'h11223344CCCC7788};
    tbl[5] = '{1'b0, 32'd7, 8'h00, 64'h0,                64'h0000456700000000};
    tbl[6] = '{1'b1, 32'd8, 8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0000456700000000};
    tbl[7] = '{1'b0, 32'd8, 8'h00, 64'h0,                64'h0};
    tbl[8] = '{1'b1, 32'd0, 8'h81, 64'h8877665544332211, 64'h0};
    tbl[9] = '{1'b0, 32'd0, 8'h00, 64'h0,                64'h8800000000000011};

    rst            = 1'b1;
    useEnable_i    = 1'b0;
    useIsWrite_i   = 1'b0;
    useWriteMask_i = '0;
    useAddr_i      = '0;
    useWriteData_i = '0;
    #12;
    check("rst_memEnable",  64'(memEnable_o),    64'd0);
    check("rst_memAddr",    64'(memAddr_o),      64'd0);
    check("rst_memMask",    64'(memWriteMask_o), 64'd0);
    check("rst_readData",   useReadData_o,       64'd0);
    check("rst_hold_idle",  64'(useHold_o),      64'd0);
    useEnable_i = 1'b1;
    #1;
    check("rst_hold_follow", 64'(useHold_o), 64'd1);
    useEnable_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_access(tbl[i].wr, tbl[i].addr, tbl[i].mask, tbl[i].data, 0, tbl[i].exp_rd,
                $sformatf("vec%0d", i));
    end

    // Read with beat 2 stalled for three cycles.
    hold_addr = 32'd14;
    hold_left = 3;
    do_access(1'b0, 32'd3, 8'h00, 64'h0, 3, 64'h11223344CCCC7788, "hold_read");

    // Reset while beat 1 of a write is on the mem port.
    begin
      beat_t b;
      int guard;
      @(posedge clk);
      #1;
      useEnable_i    = 1'b1;
      useIsWrite_i   = 1'b1;
      useAddr_i      = 32'd5;
      useWriteMask_i = 8'hFF;
      useWriteData_i = 64'hDEADBEEFCAFEF00D;
      b.wr = 1'b1; b.addr = 32'd20; b.mask = 2'b11; b.data = 16'hF00D;
      exp_q.push_back(b);
      guard = 0;
      while (memAddr_o != 32'd21 && guard < 20) begin
        @(posedge clk);
        #1;
        guard++;
      end
      check("rstmid_reached_beat1", 64'(memAddr_o), 64'd21);
      rst         = 1'b1;
      useEnable_i = 1'b0;
      #1;
      check("rstmid_memEnable", 64'(memEnable_o),    64'd0);
      check("rstmid_memAddr",   64'(memAddr_o),      64'd0);
      check("rstmid_memData",   64'(memWriteData_o), 64'd0);
      check("rstmid_readData",  useReadData_o,       64'd0);
      check("rstmid_hold",      64'(useHold_o),      64'd0);
      check("rstmid_beats_left", 64'(exp_q.size()),  64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
    end
    do_access(1'b0, 32'd3, 8'h00, 64'h0, 0, 64'h11223344CCCC7788, "post_rst_read");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
